mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters: DWIDTH, 32, memory data width; MEMSIZE, 10, word-address width.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 a_req  in  1  port A (AXI slave side) access request, held until granted.
REQ-005 a_we  in  1  port A write enable, qualified by a_req.
REQ-006 a_lock  in  1  port A burst lock, keeps ownership across consecutive accesses.
REQ-007 a_addr  in  MEMSIZE  port A word address.
REQ-008 a_wdata  in  DWIDTH  port A write data.
REQ-009 a_gnt  out  1  port A access performed this cycle.
REQ-010 a_rvalid  out  1  port A read data valid.
REQ-011 a_rdata  out  DWIDTH  port A read data.
REQ-012 b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: port B (core side), same direction, width and meaning as the A equivalents.
REQ-013 mem_we  out  1  memory write strobe.
REQ-014 mem_addr  out  MEMSIZE  memory word address.
REQ-015 mem_wdata  out  DWIDTH  memory write data.
REQ-016 mem_rdata  in  DWIDTH  memory read data, valid one cycle after a read address.

Function
REQ-017 Registered FSM with states IDLE, OWN_A, OWN_B, plus a 1-bit last-owner pointer.
REQ-018 a_gnt = (state==OWN_A) && a_req. b_gnt = (state==OWN_B) && b_req. Both are combinational and never high together.
REQ-019 In the granted cycle: mem_we = x_we, mem_addr = x_addr, mem_wdata = x_wdata of the owner. With no grant, all three are 0.
REQ-020 IDLE: a single requester moves to its OWN state at the next edge, giving 1-cycle grant latency. If both request, the port that is not last-owner wins. With no request, stay IDLE.
REQ-021 On entry to OWN_A or OWN_B, the last-owner pointer is set to that port.
REQ-022 OWN_x, x_req high and x_lock high: stay in OWN_x and grant every cycle, regardless of the other port.
REQ-023 OWN_x, x_req low or x_lock low: at the edge, move to the other OWN state if the other port requests. Otherwise stay in OWN_x if x_req is high, else go to IDLE.
REQ-024 x_rvalid is registered: it is 1 in the cycle after x_gnt && !x_we, and 0 otherwise.
REQ-025 a_rdata = b_rdata = mem_rdata, meaningful only when the matching rvalid is high.
REQ-026 Back-to-back reads by one owner give one rvalid per granted read, in order, with no bubbles.
REQ-027 An owner switch occurring in the same edge as a pending rvalid does not cancel or misroute that rvalid.

Reset
REQ-028 When rst is sampled high: state = IDLE, last-owner = B (so A wins the first tie), a_rvalid = b_rvalid = 0.
REQ-029 While rst is high: a_gnt = b_gnt = 0 and mem_we = mem_addr = mem_wdata = 0.
REQ-030 Reset asserted mid-burst aborts ownership. No access and no rvalid is issued in the cycle after reset is sampled.

Configuration
REQ-031 Macro MEM_ARB_FIXED_PRIO_EN. When defined, port A always wins IDLE ties and takes over from a non-locked B owner at the next edge even while b_req is high. The last-owner pointer is unused.
REQ-032 Without MEM_ARB_FIXED_PRIO_EN, round-robin behaviour per REQ-020 and REQ-023 applies.

Verification
REQ-033 After reset, a_req=b_req=1 in the same cycle, no locks -> a_gnt at cycle 1, b_gnt at cycle 2, then alternating A/B each cycle.
REQ-034 A write, a_we=1, a_addr=5, a_wdata=0xDEADBEEF; then B read, b_addr=5 -> mem_we=1 in A's grant cycle; b_rvalid=1 with b_rdata=0xDEADBEEF one cycle after b_gnt; a_rvalid stays 0.
REQ-035 a_lock=1 for 4 reads at addr 0..3 while b_req=1 -> b_gnt=0 for all 4 cycles; a_rvalid high for 4 consecutive cycles; b_gnt the cycle after a_lock drops.
REQ-036 rst=1 during an A locked burst with a pending read -> next cycle a_gnt=0, a_rvalid=0, mem_we=0; after release with b_req=1 only, b_gnt 1 cycle later.
REQ-037 With MEM_ARB_FIXED_PRIO_EN, both requesting continuously with no locks -> a_gnt every granted cycle and b_gnt never asserted.

Source files
------------

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb
// Description : Two-port (A/B) single-memory arbiter with burst lock and
//               round-robin tie break; MEM_ARB_FIXED_PRIO_EN selects A-priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb #(
    parameter int DWIDTH  = 32,
    parameter int MEMSIZE = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic               a_lock,
    input  logic [MEMSIZE-1:0] a_addr,
    input  logic [DWIDTH-1:0]  a_wdata,
    output logic               a_gnt,
    output logic               a_rvalid,
    output logic [DWIDTH-1:0]  a_rdata,
    input  logic               b_req,
    input  logic               b_we,
    input  logic               b_lock,
    input  logic [MEMSIZE-1:0] b_addr,
    input  logic [DWIDTH-1:0]  b_wdata,
    output logic               b_gnt,
    output logic               b_rvalid,
    output logic [DWIDTH-1:0]  b_rdata,
    output logic               mem_we,
    output logic [MEMSIZE-1:0] mem_addr,
    output logic [DWIDTH-1:0]  mem_wdata,
    input  logic [DWIDTH-1:0]  mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN_A = 2'd1,
        S_OWN_B = 2'd2
    } state_t;

    state_t r_state_q;
    state_t w_state_d;
    logic   r_a_rvalid_q;
    logic   w_a_rvalid_d;
    logic   r_b_rvalid_q;
    logic   w_b_rvalid_d;
    logic   w_tie_a;
    logic   w_a_sticky;

`ifdef MEM_ARB_FIXED_PRIO_EN
    // A wins every tie and never yields to B while it keeps requesting.
    assign w_tie_a    = 1'b1;
    assign w_a_sticky = 1'b1;
`else
    logic r_last_b_q;
    logic w_last_b_d;

    assign w_tie_a    = r_last_b_q;
    assign w_a_sticky = 1'b0;
`endif

    // Grants are gated by rst so nothing reaches memory during reset.
    assign a_gnt = !rst && (r_state_q == S_OWN_A) && a_req;
    assign b_gnt = !rst && (r_state_q == S_OWN_B) && b_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            S_IDLE: begin
                if (a_req && (!b_req || w_tie_a)) begin
                    w_state_d = S_OWN_A;
                end else if (b_req) begin
                    w_state_d = S_OWN_B;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_OWN_A: begin
                if (a_req && (a_lock || w_a_sticky)) begin
                    w_state_d = S_OWN_A;
                end else if (b_req) begin
                    w_state_d = S_OWN_B;
                end else if (a_req) begin
                    w_state_d = S_OWN_A;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_OWN_B: begin
                if (b_req && b_lock) begin
                    w_state_d = S_OWN_B;
                end else if (a_req) begin
                    w_state_d = S_OWN_A;
                end else if (b_req) begin
                    w_state_d = S_OWN_B;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    assign w_a_rvalid_d = a_gnt && !a_we;
    assign w_b_rvalid_d = b_gnt && !b_we;

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        w_last_b_d = r_last_b_q;
        if (w_state_d == S_OWN_A) begin
            w_last_b_d = 1'b0;
        end else if (w_state_d == S_OWN_B) begin
            w_last_b_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b_q <= 1'b1;
        end else begin
            r_last_b_q <= w_last_b_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= S_IDLE;
            r_a_rvalid_q <= 1'b0;
            r_b_rvalid_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_a_rvalid_q <= w_a_rvalid_d;
            r_b_rvalid_q <= w_b_rvalid_d;
        end
    end

    assign a_rvalid = r_a_rvalid_q;
    assign b_rvalid = r_b_rvalid_q;
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arb
// Description : Directed self-checking bench for mem_arb with a read-data
//               scoreboard; honours MEM_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    localparam int DW = 32;
    localparam int AW = 10;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, a_lock = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0, b_lock = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;
    logic [DW-1:0] a_rdata, b_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] a_q [$];
    logic [DW-1:0] b_q [$];
    logic [DW-1:0] ref_mem [int];

    logic [DW-1:0] ram     [0:(1<<AW)-1];
    bit            ram_vld [0:(1<<AW)-1];

    always #5 clk = ~clk;

    mem_arb #(.DWIDTH(DW), .MEMSIZE(AW)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] ad);
        return 32'hA500_0000 | {22'd0, ad};
    endfunction

    // Synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]     <= mem_wdata;
            ram_vld[mem_addr] <= 1'b1;
        end
        mem_rdata <= ram_vld[mem_addr] ? ram[mem_addr] : pat(mem_addr);
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] ad);
        return ref_mem.exists(int'(ad)) ? ref_mem[int'(ad)] : pat(ad);
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One bus cycle: inputs already driven; check outputs, update scoreboard, advance.
    task automatic cyc(input bit ea, input bit eb);
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        #2;
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, ea});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, eb});
        e_we = 1'b0; e_addr = '0; e_wd = '0;
        if (ea) begin
            e_we = a_we; e_addr = a_addr; e_wd = a_wdata;
        end else if (eb) begin
            e_we = b_we; e_addr = b_addr; e_wd = b_wdata;
        end
        chk("mem_we", {31'd0, mem_we}, {31'd0, e_we});
        chk("mem_addr", {22'd0, mem_addr}, {22'd0, e_addr});
        chk("mem_wdata", mem_wdata, e_wd);
        chk("a_rvalid", {31'd0, a_rvalid}, {31'd0, (a_q.size() > 0)});
        if (a_q.size() > 0) chk("a_rdata", a_rdata, a_q.pop_front());
        chk("b_rvalid", {31'd0, b_rvalid}, {31'd0, (b_q.size() > 0)});
        if (b_q.size() > 0) chk("b_rdata", b_rdata, b_q.pop_front());
        if (ea && !a_we) a_q.push_back(ref_rd(a_addr));
        if (eb && !b_we) b_q.push_back(ref_rd(b_addr));
        if (ea && a_we) ref_mem[int'(a_addr)] = a_wdata;
        if (eb && b_we) ref_mem[int'(b_addr)] = b_wdata;
        if (rst) begin
            a_q.delete();
            b_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, with both ports requesting to show grants stay off.
        rst = 1'b1; a_req = 1'b1; b_req = 1'b1;
        @(posedge clk); #1;
        cyc(0, 0);
        rst = 1'b0;

        // Simultaneous requests: A first, then alternation (A only when fixed priority).
        a_addr = 10'd1; b_addr = 10'd2;
        cyc(0, 0);
        cyc(1, 0);
        cyc(FIXED, !FIXED);
        cyc(1, 0);
        cyc(FIXED, !FIXED);
        a_req = 1'b0; b_req = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        // A writes 0xDEADBEEF to address 5, B reads it back.
        a_req = 1'b1; a_we = 1'b1; a_addr = 10'd5; a_wdata = 32'hDEAD_BEEF;
        cyc(0, 0);
        cyc(1, 0);
        a_req = 1'b0; a_we = 1'b0; a_wdata = '0;
        b_req = 1'b1; b_addr = 10'd5;
        cyc(0, 0);
        cyc(0, 1);
        b_req = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        // Locked A burst of four reads while B keeps requesting.
        a_req = 1'b1; a_lock = 1'b1; a_addr = 10'd0; b_req = 1'b1; b_addr = 10'd7;
        cyc(0, 0);
        for (int i = 0; i < 4; i++) begin
            a_addr = AW'(i);
            cyc(1, 0);
        end
        a_req = 1'b0; a_lock = 1'b0;
        cyc(0, 0);
        cyc(0, 1);
        b_req = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        // Reset in the middle of a locked A burst with a read outstanding.
        a_req = 1'b1; a_lock = 1'b1; a_addr = 10'd8;
        cyc(0, 0);
        cyc(1, 0);
        a_addr = 10'd9; b_req = 1'b1; b_addr = 10'd3;
        cyc(1, 0);
        rst = 1'b1;
        cyc(0, 0);
        rst = 1'b0; a_req = 1'b0; a_lock = 1'b0;
        cyc(0, 0);
        cyc(0, 1);
        b_req = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
